// File: rtl/neuron_mac_bank.sv
// Captures streamed weights per unit, then computes one signed dot product per unit, one multiply per cycle.
// Latency: first result 4 edges after the start edge, then one every 4 edges; done 1 edge after the last result.
// Backpressure: none; results are pulses that the consumer must take. Writes are dropped while busy.
module neuron_mac_bank #(
    parameter int DATA_W   = 8,
    parameter int N_UNITS  = 4,
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            ram_data,
    input  logic                         write,
    input  logic [$clog2(N_UNITS)-1:0]   unit_sel,
    input  logic [$clog2(N_INPUTS)-1:0]  unit_address,
    input  logic                         sum_trigger,
    input  logic [N_INPUTS*DATA_W-1:0]   in_vec,
    output logic [ACC_W-1:0]             unit_result,
    output logic [$clog2(N_UNITS)-1:0]   result_unit,
    output logic                         result_valid,
    output logic                         busy,
    output logic                         done
);
    localparam int UW = $clog2(N_UNITS);
    localparam int IW = $clog2(N_INPUTS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                                        state_q, state_d;
    logic [N_UNITS-1:0][N_INPUTS-1:0][DATA_W-1:0]  weight_q, weight_d;
    logic [N_INPUTS-1:0][DATA_W-1:0]               in_reg_q, in_reg_d;
    logic signed [ACC_W-1:0]                       acc_q, acc_d;
    logic [UW-1:0]                                 unit_q, unit_d;
    logic [IW-1:0]                                 idx_q, idx_d;
    logic                                          trig_q, trig_d;
    logic [ACC_W-1:0]                              result_q, result_d;
    logic [UW-1:0]                                 runit_q, runit_d;
    logic                                          rvld_q, rvld_d;
    logic                                          busy_q, busy_d;
    logic                                          done_q, done_d;

    logic signed [2*DATA_W-1:0]                    prod;
    logic signed [ACC_W-1:0]                       acc_next;

    // The accumulator is wide enough for N_INPUTS worst-case products, so no saturation is needed.
    assign prod     = $signed(weight_q[unit_q][idx_q]) * $signed(in_reg_q[idx_q]);
    assign acc_next = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        in_reg_d = in_reg_q;
        acc_d    = acc_q;
        unit_d   = unit_q;
        idx_d    = idx_q;
        trig_d   = sum_trigger;
        result_d = result_q;
        runit_d  = runit_q;
        rvld_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (write) weight_d[unit_sel][unit_address] = ram_data;
                if (sum_trigger && !trig_q) begin
                    in_reg_d = in_vec;
                    unit_d   = '0;
                    idx_d    = '0;
                    acc_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = MAC;
                end
            end
            MAC: begin
                if (idx_q == IW'(N_INPUTS-1)) begin
                    result_d = acc_next;
                    runit_d  = unit_q;
                    rvld_d   = 1'b1;
                    acc_d    = '0;
                    idx_d    = '0;
                    if (unit_q == UW'(N_UNITS-1)) state_d = DONE;
                    else                          unit_d  = unit_q + UW'(1);
                end else begin
                    acc_d = acc_next;
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            weight_q <= '0;
            in_reg_q <= '0;
            acc_q    <= '0;
            unit_q   <= '0;
            idx_q    <= '0;
            trig_q   <= 1'b0;
            result_q <= '0;
            runit_q  <= '0;
            rvld_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            weight_q <= weight_d;
            in_reg_q <= in_reg_d;
            acc_q    <= acc_d;
            unit_q   <= unit_d;
            idx_q    <= idx_d;
            trig_q   <= trig_d;
            result_q <= result_d;
            runit_q  <= runit_d;
            rvld_q   <= rvld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign unit_result  = result_q;
    assign result_unit  = runit_q;
    assign result_valid = rvld_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_neuron_mac_bank.sv
// Directed bench for neuron_mac_bank: loads weights, triggers runs, checks results, timing and control corner cases.
module tb_neuron_mac_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ram_data = '0;
    logic        write = 1'b0;
    logic [1:0]  unit_sel = '0;
    logic [1:0]  unit_address = '0;
    logic        sum_trigger = 1'b0;
    logic [31:0] in_vec = '0;
    logic [17:0] unit_result;
    logic [1:0]  result_unit;
    logic        result_valid;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ru_q[$];
    int rv_q[$];
    int rc_q[$];
    int dc_q[$];

    neuron_mac_bank dut (
        .clk(clk), .reset(reset), .ram_data(ram_data), .write(write),
        .unit_sel(unit_sel), .unit_address(unit_address), .sum_trigger(sum_trigger),
        .in_vec(in_vec), .unit_result(unit_result), .result_unit(result_unit),
        .result_valid(result_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every result pulse and done pulse together with the edge count it followed.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            ru_q.push_back(int'(result_unit));
            rv_q.push_back(int'($signed(unit_result)));
            rc_q.push_back(cyc);
        end
        if (done === 1'b1) dc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        ru_q.delete(); rv_q.delete(); rc_q.delete(); dc_q.delete();
    endtask

    task automatic write_w(input int u, input int a, input int d);
        @(negedge clk);
        write = 1'b1; unit_sel = 2'(u); unit_address = 2'(a); ram_data = 8'(d);
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic set_vec(input int a, input int b, input int c, input int d);
        in_vec = {8'(d), 8'(c), 8'(b), 8'(a)};
    endtask

    // Raise the trigger at a negedge; the start edge k is the next rising edge.
    task automatic start_run(input string tag, input int hold, output int k);
        @(negedge clk);
        sum_trigger = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        check({tag, "_busy_after_start"}, busy, 1);
        repeat (hold - 1) @(negedge clk);
        sum_trigger = 1'b0;
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int b = budget;
        while (dc_q.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        check({tag, "_done_seen"}, dc_q.size() >= n, 1);
        check({tag, "_busy_low_after_done"}, busy, 0);
    endtask

    task automatic check_run(input string tag, input int base, input int k,
                             input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        if (rv_q.size() < base + 4) begin
            check({tag, "_result_count"}, rv_q.size(), base + 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_unit%0d_idx", tag, i), ru_q[base+i], i);
                check($sformatf("%s_unit%0d_val", tag, i), rv_q[base+i], e[i]);
                check($sformatf("%s_unit%0d_time", tag, i), rc_q[base+i], k + 4*(i+1));
            end
        end
        if (dc_q.size() > base / 4) check({tag, "_done_time"}, dc_q[base/4], k + 17);
    endtask

    int k, k2;

    initial begin
        #12;
        check("rst_unit_result", unit_result, 0);
        check("rst_result_unit", result_unit, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic run: unit0 weights 1..4, others 1, inputs all 1.
        for (int u = 0; u < 4; u++)
            for (int a = 0; a < 4; a++)
                write_w(u, a, (u == 0) ? a + 1 : 1);
        set_vec(1, 1, 1, 1);
        clear_logs();
        start_run("basic", 2, k);
        wait_dones("basic", 1, 40);
        repeat (25) @(negedge clk);
        check_run("basic", 0, k, 10, 4, 4, 4);
        check("basic_one_run", rv_q.size(), 4);

        // Signed extremes: -128 weights against -128 and 127 inputs.
        for (int u = 0; u < 2; u++)
            for (int a = 0; a < 4; a++)
                write_w(u, a, -128);
        set_vec(-128, -128, -128, -128);
        clear_logs();
        start_run("neg", 2, k);
        wait_dones("neg", 1, 40);
        check_run("neg", 0, k, 65536, 65536, -512, -512);
        set_vec(127, 127, 127, 127);
        clear_logs();
        start_run("mix", 2, k);
        wait_dones("mix", 1, 40);
        check_run("mix", 0, k, -65024, -65024, 508, 508);

        // Write while busy must be dropped.
        clear_logs();
        start_run("wbusy", 2, k);
        repeat (4) @(negedge clk);
        write_w(0, 0, 99);
        wait_dones("wbusy", 1, 40);
        check_run("wbusy", 0, k, -65024, -65024, 508, 508);
        clear_logs();
        start_run("wbusy2", 2, k);
        wait_dones("wbusy2", 1, 40);
        check_run("wbusy2", 0, k, -65024, -65024, 508, 508);

        // Asynchronous reset during unit 2 accumulation.
        clear_logs();
        start_run("rst_mid", 2, k);
        repeat (9) @(negedge clk);
        check("rst_mid_pre_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("rst_mid_unit_result", unit_result, 0);
        check("rst_mid_result_unit", result_unit, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", result_valid, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        set_vec(1, 1, 1, 1);
        clear_logs();
        start_run("post_rst", 2, k);
        wait_dones("post_rst", 1, 40);
        check_run("post_rst", 0, k, 0, 0, 0, 0);

        // Trigger held across done, then a fresh edge; in_vec changes after second start.
        for (int a = 0; a < 4; a++) write_w(0, a, a + 1);
        set_vec(1, 1, 1, 1);
        clear_logs();
        start_run("held", 25, k);
        @(negedge clk);
        @(negedge clk);
        sum_trigger = 1'b1;
        k2 = cyc + 1;
        @(negedge clk);
        set_vec(2, 2, 2, 2);
        repeat (2) @(negedge clk);
        sum_trigger = 1'b0;
        wait_dones("held", 2, 60);
        repeat (25) @(negedge clk);
        check("held_run_count", dc_q.size(), 2);
        check("held_result_count", rv_q.size(), 8);
        check_run("held_r1", 0, k, 10, 0, 0, 0);
        check_run("held_r2", 4, k2, 10, 0, 0, 0);

        // Same-edge write and start uses the freshly written weight.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        write_w(0, 0, 1);
        set_vec(1, 0, 0, 0);
        clear_logs();
        @(negedge clk);
        write = 1'b1; unit_sel = 2'd0; unit_address = 2'd0; ram_data = 8'd5;
        sum_trigger = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        sum_trigger = 1'b0;
        wait_dones("same_edge", 1, 40);
        check_run("same_edge", 0, k, 5, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
